// File: rtl/axi_clint_xbar_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_clint_xbar_if
// Description : Single-beat AXI4-lite style bus (AR/R/AW/W/B) used on both
//               the upstream and io_master sides of axi_clint_xbar.
// Revision    : 1.0  initial release
// ============================================================================
interface axi_clint_xbar_if;
  // Read address channel
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  // Read data channel
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  // Write address channel
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  // Write data channel
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  // Write response channel
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  // Transaction initiator side
  modport master (
    output arvalid, araddr, arsize, rready,
    output awvalid, awaddr, awsize, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp,
    input  awready, wready, bvalid, bresp
  );

  // Transaction target side
  modport slave (
    input  arvalid, araddr, arsize, rready,
    input  awvalid, awaddr, awsize, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp,
    output awready, wready, bvalid, bresp
  );
endinterface
`default_nettype wire

// File: rtl/axi_clint_xbar.sv
`default_nettype none
// ============================================================================
// Module      : axi_clint_xbar
// Description : 1-to-2 address-routing crossbar. Upstream requests that fall
//               inside the CLINT window are served locally (64-bit mtime
//               counter); everything else is forwarded to io_master. One
//               outstanding transaction per direction, reads and writes
//               sequenced independently.
// Revision    : 1.0  initial release
// ============================================================================
module axi_clint_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_SIZE = 32'h0001_0000,
  parameter int unsigned MTIME_DIV  = 1
) (
  input  wire                 clk,
  input  wire                 rst_n,
  axi_clint_xbar_if.slave     s,
  axi_clint_xbar_if.master    m,
  output logic [63:0]         mtime
);

  localparam logic [31:0] c_off_mtime_lo = 32'h0000_BFF8;
  localparam logic [31:0] c_off_mtime_hi = 32'h0000_BFFC;
  localparam logic [31:0] c_presc_last   = 32'(MTIME_DIV - 1);
  localparam logic [1:0]  c_resp_okay    = 2'b00;
  localparam logic [1:0]  c_resp_slverr  = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_EXT_AR = 2'd1,
    R_EXT_R  = 2'd2,
    R_CLINT  = 2'd3
  } r_state_t;

  typedef enum logic [2:0] {
    W_IDLE    = 3'd0,
    W_DATA    = 3'd1,
    W_EXT     = 3'd2,
    W_EXT_B   = 3'd3,
    W_CLINT_B = 3'd4
  } w_state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  r_state_t    r_rstate;
  r_state_t    w_rstate_nxt;
  w_state_t    r_wstate;
  w_state_t    w_wstate_nxt;

  logic [63:0] r_mtime;
  logic [31:0] r_presc;
  logic        w_presc_wrap;

  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [31:0] w_ar_off;
  logic        w_ar_hit;
  logic        w_ar_fire;
  logic [31:0] w_clint_rdata;
  logic [1:0]  w_clint_rresp;

  logic [31:0] r_awaddr;
  logic [2:0]  r_awsize;
  logic        r_aw_hit;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_bresp;
  logic        r_aw_pend;
  logic        r_w_pend;
  logic [31:0] w_aw_off;
  logic        w_aw_hit;
  logic        w_aw_fire;
  logic        w_w_fire;
  logic        w_wr_lo;
  logic        w_wr_hi;
  logic        w_clint_wr;
  logic [31:0] w_merge_half;

  assign mtime = r_mtime;

  // --------------------------------------------------------------------------
  // Address decode (unsigned wrap-around window compare)
  // --------------------------------------------------------------------------
  assign w_ar_off  = s.araddr - CLINT_BASE;
  assign w_ar_hit  = (w_ar_off < CLINT_SIZE);
  assign w_ar_fire = (r_rstate == R_IDLE) && s.arvalid;

  assign w_aw_off  = s.awaddr - CLINT_BASE;
  assign w_aw_hit  = (w_aw_off < CLINT_SIZE);
  assign w_aw_fire = (r_wstate == W_IDLE) && s.awvalid;
  assign w_w_fire  = (r_wstate == W_DATA) && s.wvalid;

  // Offsets of the latched write address, used during the data beat
  assign w_wr_lo    = ((r_awaddr - CLINT_BASE) == c_off_mtime_lo);
  assign w_wr_hi    = ((r_awaddr - CLINT_BASE) == c_off_mtime_hi);
  assign w_clint_wr = w_w_fire && r_aw_hit;

  // CLINT read data sampled at the AR handshake so a same-cycle write is not seen
  always_comb begin
    w_clint_rdata = 32'h0;
    w_clint_rresp = c_resp_slverr;
    if (w_ar_off == c_off_mtime_lo) begin
      w_clint_rdata = r_mtime[31:0];
      w_clint_rresp = c_resp_okay;
    end else if (w_ar_off == c_off_mtime_hi) begin
      w_clint_rdata = r_mtime[63:32];
      w_clint_rresp = c_resp_okay;
    end
  end

  // Byte-merge the incoming write beat into the addressed half of mtime
  always_comb begin
    w_merge_half = w_wr_hi ? r_mtime[63:32] : r_mtime[31:0];
    for (int i = 0; i < 4; i++) begin
      if (s.wstrb[i]) begin
        w_merge_half[8*i +: 8] = s.wdata[8*i +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // mtime counter with prescaler; a CLINT write overrides the increment
  // --------------------------------------------------------------------------
  assign w_presc_wrap = (r_presc == c_presc_last);

  // Prescaler keeps running through writes; mtime either loads or counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= 32'h0;
      r_mtime <= 64'h0;
    end else begin
      r_presc <= w_presc_wrap ? 32'h0 : (r_presc + 32'd1);
      if (w_clint_wr && w_wr_lo) begin
        r_mtime[31:0] <= w_merge_half;
      end else if (w_clint_wr && w_wr_hi) begin
        r_mtime[63:32] <= w_merge_half;
      end else if (w_presc_wrap) begin
        r_mtime <= r_mtime + 64'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  // Read state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  // Read next-state and channel outputs; external R is a pure pass-through
  always_comb begin
    w_rstate_nxt = r_rstate;
    s.arready    = 1'b0;
    s.rvalid     = 1'b0;
    s.rdata      = 32'h0;
    s.rresp      = c_resp_okay;
    m.arvalid    = 1'b0;
    m.araddr     = r_araddr;
    m.arsize     = r_arsize;
    m.rready     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        s.arready = 1'b1;
        if (s.arvalid) begin
          w_rstate_nxt = w_ar_hit ? R_CLINT : R_EXT_AR;
        end
      end
      R_EXT_AR: begin
        m.arvalid = 1'b1;
        if (m.arready) begin
          w_rstate_nxt = R_EXT_R;
        end
      end
      R_EXT_R: begin
        s.rvalid = m.rvalid;
        s.rdata  = m.rdata;
        s.rresp  = m.rresp;
        m.rready = s.rready;
        if (m.rvalid && s.rready) begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_CLINT: begin
        s.rvalid = 1'b1;
        s.rdata  = r_rdata;
        s.rresp  = r_rresp;
        if (s.rready) begin
          w_rstate_nxt = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read payload capture at the AR handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_araddr <= 32'h0;
      r_arsize <= 3'h0;
      r_rdata  <= 32'h0;
      r_rresp  <= c_resp_okay;
    end else if (w_ar_fire) begin
      r_araddr <= s.araddr;
      r_arsize <= s.arsize;
      r_rdata  <= w_clint_rdata;
      r_rresp  <= w_clint_rresp;
    end
  end

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  // Write state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  // Write next-state and channel outputs; AW and W downstream retire independently
  always_comb begin
    w_wstate_nxt = r_wstate;
    s.awready    = 1'b0;
    s.wready     = 1'b0;
    s.bvalid     = 1'b0;
    s.bresp      = c_resp_okay;
    m.awvalid    = 1'b0;
    m.awaddr     = r_awaddr;
    m.awsize     = r_awsize;
    m.wvalid     = 1'b0;
    m.wdata      = r_wdata;
    m.wstrb      = r_wstrb;
    m.bready     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        s.awready = 1'b1;
        if (s.awvalid) begin
          w_wstate_nxt = W_DATA;
        end
      end
      W_DATA: begin
        s.wready = 1'b1;
        if (s.wvalid) begin
          w_wstate_nxt = r_aw_hit ? W_CLINT_B : W_EXT;
        end
      end
      W_EXT: begin
        m.awvalid = r_aw_pend;
        m.wvalid  = r_w_pend;
        if ((!r_aw_pend || m.awready) && (!r_w_pend || m.wready)) begin
          w_wstate_nxt = W_EXT_B;
        end
      end
      W_EXT_B: begin
        s.bvalid = m.bvalid;
        s.bresp  = m.bresp;
        m.bready = s.bready;
        if (m.bvalid && s.bready) begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_CLINT_B: begin
        s.bvalid = 1'b1;
        s.bresp  = r_bresp;
        if (s.bready) begin
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write payload capture and downstream AW/W pending flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awaddr  <= 32'h0;
      r_awsize  <= 3'h0;
      r_aw_hit  <= 1'b0;
      r_wdata   <= 32'h0;
      r_wstrb   <= 4'h0;
      r_bresp   <= c_resp_okay;
      r_aw_pend <= 1'b0;
      r_w_pend  <= 1'b0;
    end else begin
      if (w_aw_fire) begin
        r_awaddr <= s.awaddr;
        r_awsize <= s.awsize;
        r_aw_hit <= w_aw_hit;
      end
      if (w_w_fire) begin
        r_wdata   <= s.wdata;
        r_wstrb   <= s.wstrb;
        r_bresp   <= (w_wr_lo || w_wr_hi) ? c_resp_okay : c_resp_slverr;
        r_aw_pend <= !r_aw_hit;
        r_w_pend  <= !r_aw_hit;
      end else if (r_wstate == W_EXT) begin
        if (m.awready) begin
          r_aw_pend <= 1'b0;
        end
        if (m.wready) begin
          r_w_pend <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_clint_xbar.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_clint_xbar
// Description : Self-checking bench for axi_clint_xbar with a behavioural
//               mtime model and randomized CLINT / external traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi_clint_xbar;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] SIZE = 32'h0001_0000;
  localparam int unsigned DIV  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] mtime;
  int          errors = 0;
  int          checks = 0;

  axi_clint_xbar_if s_bus ();
  axi_clint_xbar_if m_bus ();

  axi_clint_xbar #(
    .CLINT_BASE (BASE),
    .CLINT_SIZE (SIZE),
    .MTIME_DIV  (DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (s_bus),
    .m     (m_bus),
    .mtime (mtime)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_clint(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < SIZE;
  endfunction

  function automatic void clint_exp(input logic [31:0] a, input logic [63:0] mt,
                                    output logic [31:0] d, output logic [1:0] r);
    logic [31:0] off;
    off = a - BASE;
    if (off == 32'hBFF8) begin d = mt[31:0];  r = 2'b00; end
    else if (off == 32'hBFFC) begin d = mt[63:32]; r = 2'b00; end
    else begin d = 32'h0; r = 2'b10; end
  endfunction

  // ---------------- behavioural mtime model ----------------
  logic [63:0] mdl_mtime;
  int unsigned mdl_presc;
  logic [31:0] mdl_waddr = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_mtime = 64'h0;
      mdl_presc = 0;
    end else begin : model_step
      logic [31:0] off;
      logic        wrote;
      wrote = 1'b0;
      off = mdl_waddr - BASE;
      if (s_bus.wvalid && s_bus.wready && is_clint(mdl_waddr) &&
          (off == 32'hBFF8 || off == 32'hBFFC)) begin
        for (int i = 0; i < 4; i++) begin
          if (s_bus.wstrb[i]) begin
            if (off == 32'hBFF8) mdl_mtime[8*i +: 8] = s_bus.wdata[8*i +: 8];
            else                 mdl_mtime[32 + 8*i +: 8] = s_bus.wdata[8*i +: 8];
          end
        end
        wrote = 1'b1;
      end
      if (mdl_presc == DIV - 1) begin
        mdl_presc = 0;
        if (!wrote) mdl_mtime = mdl_mtime + 64'd1;
      end else begin
        mdl_presc = mdl_presc + 1;
      end
    end
  end

  // Per-cycle comparison of the exported counter against the model
  always @(negedge clk) begin
    if (rst_n) chk("mtime_track", mtime, mdl_mtime);
  end

  // ---------------- bus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_handshake(input logic [31:0] addr, input logic [2:0] size,
                              output logic [63:0] mt);
    int n;
    n = 0;
    s_bus.arvalid = 1'b1;
    s_bus.araddr  = addr;
    s_bus.arsize  = size;
    while (!s_bus.arready && n < 50) begin tick(); n++; end
    chk("ar_wait", (n < 50), 1);
    mt = mdl_mtime;
    tick();
    s_bus.arvalid = 1'b0;
  endtask

  task automatic aw_handshake(input logic [31:0] addr, input logic [2:0] size);
    int n;
    n = 0;
    s_bus.awvalid = 1'b1;
    s_bus.awaddr  = addr;
    s_bus.awsize  = size;
    while (!s_bus.awready && n < 50) begin tick(); n++; end
    chk("aw_wait", (n < 50), 1);
    mdl_waddr = addr;
    tick();
    s_bus.awvalid = 1'b0;
    chk("wready_after_aw", s_bus.wready, 1);
  endtask

  task automatic w_handshake(input logic [31:0] data, input logic [3:0] strb);
    s_bus.wvalid = 1'b1;
    s_bus.wdata  = data;
    s_bus.wstrb  = strb;
    tick();
    s_bus.wvalid = 1'b0;
  endtask

  task automatic clint_r_phase(input logic [31:0] ed, input logic [1:0] er,
                               output logic [31:0] d, output logic [1:0] r);
    int stall;
    chk("clint_rvalid", s_bus.rvalid, 1);
    stall = $urandom_range(0, 2);
    repeat (stall) begin
      tick();
      chk("clint_rvalid_hold", s_bus.rvalid, 1);
      chk("clint_rdata_hold", s_bus.rdata, ed);
    end
    d = s_bus.rdata;
    r = s_bus.rresp;
    chk("clint_rdata", d, ed);
    chk("clint_rresp", r, er);
    s_bus.rready = 1'b1;
    tick();
    s_bus.rready = 1'b0;
    chk("r_back_idle", s_bus.arready, 1);
  endtask

  task automatic clint_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    logic [63:0] mt;
    logic [31:0] ed;
    logic [1:0]  er;
    ar_handshake(addr, 3'd2, mt);
    clint_exp(addr, mt, ed, er);
    clint_r_phase(ed, er, d, r);
  endtask

  task automatic ext_read(input logic [31:0] addr, input int ar_dly,
                          input logic [31:0] data, input logic [1:0] resp);
    logic [63:0] mt;
    logic [2:0]  size;
    int          rdly;
    size = 3'($urandom_range(0, 2));
    ar_handshake(addr, size, mt);
    for (int c = 0; c <= ar_dly; c++) begin
      m_bus.arready = (c == ar_dly);
      chk("m_arvalid", m_bus.arvalid, 1);
      chk("m_araddr", m_bus.araddr, addr);
      chk("m_arsize", m_bus.arsize, size);
      chk("s_rvalid_during_ar", s_bus.rvalid, 0);
      tick();
    end
    m_bus.arready = 1'b0;
    chk("m_arvalid_drop", m_bus.arvalid, 0);
    rdly = $urandom_range(0, 2);
    repeat (rdly) begin
      chk("s_rvalid_early", s_bus.rvalid, 0);
      tick();
    end
    m_bus.rvalid = 1'b1;
    m_bus.rdata  = data;
    m_bus.rresp  = resp;
    #1;
    chk("pt_rvalid", s_bus.rvalid, 1);
    chk("pt_rdata", s_bus.rdata, data);
    chk("pt_rresp", s_bus.rresp, resp);
    chk("pt_rready_lo", m_bus.rready, 0);
    tick();
    s_bus.rready = 1'b1;
    #1;
    chk("pt_rready_hi", m_bus.rready, 1);
    tick();
    m_bus.rvalid = 1'b0;
    s_bus.rready = 1'b0;
    #1;
    chk("ext_r_idle", s_bus.arready, 1);
    chk("ext_r_mrready", m_bus.rready, 0);
  endtask

  task automatic b_phase(input logic [1:0] er, output logic [1:0] r);
    int stall;
    chk("clint_bvalid", s_bus.bvalid, 1);
    stall = $urandom_range(0, 2);
    repeat (stall) begin
      tick();
      chk("clint_bvalid_hold", s_bus.bvalid, 1);
    end
    r = s_bus.bresp;
    chk("clint_bresp", r, er);
    s_bus.bready = 1'b1;
    tick();
    s_bus.bready = 1'b0;
    chk("w_back_idle", s_bus.awready, 1);
  endtask

  task automatic clint_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] r);
    logic [31:0] off;
    off = addr - BASE;
    aw_handshake(addr, 3'd2);
    w_handshake(data, strb);
    b_phase((off == 32'hBFF8 || off == 32'hBFFC) ? 2'b00 : 2'b10, r);
  endtask

  task automatic ext_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input logic [1:0] bresp);
    logic [2:0] size;
    int         last;
    size = 3'($urandom_range(0, 2));
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    aw_handshake(addr, size);
    w_handshake(data, strb);
    // Response offered early: it must not reach upstream before both handshakes
    m_bus.bvalid = 1'b1;
    m_bus.bresp  = bresp;
    for (int c = 0; c <= last; c++) begin
      m_bus.awready = (c == aw_dly);
      m_bus.wready  = (c == w_dly);
      chk("m_awvalid", m_bus.awvalid, (c <= aw_dly));
      chk("m_wvalid", m_bus.wvalid, (c <= w_dly));
      chk("s_bvalid_early", s_bus.bvalid, 0);
      if (c <= aw_dly) begin
        chk("m_awaddr", m_bus.awaddr, addr);
        chk("m_awsize", m_bus.awsize, size);
      end
      if (c <= w_dly) begin
        chk("m_wdata", m_bus.wdata, data);
        chk("m_wstrb", m_bus.wstrb, strb);
      end
      tick();
    end
    m_bus.awready = 1'b0;
    m_bus.wready  = 1'b0;
    chk("pt_bvalid", s_bus.bvalid, 1);
    chk("pt_bresp", s_bus.bresp, bresp);
    chk("pt_bready_lo", m_bus.bready, 0);
    s_bus.bready = 1'b1;
    #1;
    chk("pt_bready_hi", m_bus.bready, 1);
    tick();
    s_bus.bready = 1'b0;
    m_bus.bvalid = 1'b0;
    chk("ext_w_idle", s_bus.awready, 1);
  endtask

  function automatic logic [31:0] rand_clint_addr();
    case ($urandom_range(0, 2))
      0:       return BASE + 32'hBFF8;
      1:       return BASE + 32'hBFFC;
      default: return BASE + (32'($urandom_range(0, 16383)) << 2);
    endcase
  endfunction

  function automatic logic [31:0] rand_ext_addr();
    return 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
  endfunction

  task automatic do_read(input logic [31:0] addr);
    logic [31:0] d;
    logic [1:0]  r;
    if (is_clint(addr)) clint_read(addr, d, r);
    else ext_read(addr, $urandom_range(0, 3), $urandom, $urandom_range(0, 1) ? 2'b10 : 2'b00);
  endtask

  task automatic do_write(input logic [31:0] addr);
    logic [1:0] r;
    if (is_clint(addr)) clint_write(addr, $urandom, 4'($urandom_range(0, 15)), r);
    else ext_write(addr, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1) ? 2'b10 : 2'b00);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] d;
    logic [1:0]  r;
    logic [63:0] mt;
    logic [31:0] ed;
    logic [1:0]  er;
    logic [31:0] tbl [6];

    s_bus.arvalid = 0; s_bus.araddr = 0; s_bus.arsize = 0; s_bus.rready = 0;
    s_bus.awvalid = 0; s_bus.awaddr = 0; s_bus.awsize = 0;
    s_bus.wvalid = 0; s_bus.wdata = 0; s_bus.wstrb = 0; s_bus.bready = 0;
    m_bus.arready = 0; m_bus.rvalid = 0; m_bus.rdata = 0; m_bus.rresp = 0;
    m_bus.awready = 0; m_bus.wready = 0; m_bus.bvalid = 0; m_bus.bresp = 0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mtime", mtime, 0);
    chk("rst_arready", s_bus.arready, 1);
    chk("rst_awready", s_bus.awready, 1);
    chk("rst_wready", s_bus.wready, 0);
    chk("rst_m_rready", m_bus.rready, 0);
    chk("rst_m_bready", m_bus.bready, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("idle10_mtime", mtime, 64'd10);
    chk("idle_rvalid", s_bus.rvalid, 0);
    chk("idle_bvalid", s_bus.bvalid, 0);
    chk("idle_m_arvalid", m_bus.arvalid, 0);
    chk("idle_m_awvalid", m_bus.awvalid, 0);
    chk("idle_m_wvalid", m_bus.wvalid, 0);
    chk("idle_arready", s_bus.arready, 1);
    chk("idle_awready", s_bus.awready, 1);

    // Partial-strobe write of the upper half onto a zero upper half
    clint_write(BASE + 32'hBFFC, 32'h1234_5678, 4'b0011, r);
    chk("lit_hi_merge", mtime[63:32], 32'h0000_5678);
    chk("lit_hi_bresp", r, 2'b00);
    clint_write(BASE, 32'hFFFF_FFFF, 4'hF, r);
    chk("lit_slverr_bresp", r, 2'b10);
    chk("lit_hi_unchanged", mtime[63:32], 32'h0000_5678);

    // Upper half = 1, then read it back
    clint_write(BASE + 32'hBFFC, 32'h0000_0001, 4'hF, r);
    clint_read(BASE + 32'hBFFC, d, r);
    chk("lit_rd_hi", d, 32'h0000_0001);
    chk("lit_rd_hi_resp", r, 2'b00);

    // Lower half = FFFF_FFFE; read captured the cycle right after the write
    aw_handshake(BASE + 32'hBFF8, 3'd2);
    w_handshake(32'hFFFF_FFFE, 4'hF);
    clint_read(BASE + 32'hBFF8, d, r);
    chk("lit_rd_lo", d, 32'hFFFF_FFFE);
    chk("lit_rd_lo_resp", r, 2'b00);
    b_phase(2'b00, r);
    clint_read(BASE + 32'hBFFC, d, r);

    // Read and write captured in the same cycle: read returns pre-write value
    aw_handshake(BASE + 32'hBFFC, 3'd2);
    s_bus.wvalid = 1'b1; s_bus.wdata = 32'hA5A5_A5A5; s_bus.wstrb = 4'hF;
    s_bus.arvalid = 1'b1; s_bus.araddr = BASE + 32'hBFFC; s_bus.arsize = 3'd2;
    mt = mdl_mtime;
    tick();
    s_bus.wvalid = 1'b0;
    s_bus.arvalid = 1'b0;
    chk("lit_same_cycle_wr", mtime[63:32], 32'hA5A5_A5A5);
    clint_exp(BASE + 32'hBFFC, mt, ed, er);
    clint_r_phase(ed, er, d, r);
    b_phase(2'b00, r);

    // External read with 3-cycle AR stall, external write with W before AW
    ext_read(32'h8000_0000, 3, 32'hDEAD_BEEF, 2'b00);
    ext_write(32'h8000_0010, 32'hCAFE_F00D, 4'hF, 3, 1, 2'b10);

    // Window boundaries
    tbl[0] = 32'h01FF_FFFC; tbl[1] = 32'h0201_0000; tbl[2] = 32'h0200_FFFC;
    tbl[3] = 32'h0200_0000; tbl[4] = 32'hFFFF_FFFC; tbl[5] = 32'h0200_BFF4;
    foreach (tbl[i]) begin
      do_read(tbl[i]);
      do_write(tbl[i]);
    end
    clint_read(32'h0200_FFFC, d, r);
    chk("lit_last_word_resp", r, 2'b10);
    chk("lit_last_word_data", d, 32'h0);

    // Randomized traffic, reads and writes overlapping
    for (int it = 0; it < 40; it++) begin
      fork
        begin
          repeat ($urandom_range(0, 2)) tick();
          do_read($urandom_range(0, 1) ? rand_clint_addr() : rand_ext_addr());
        end
        begin
          repeat ($urandom_range(0, 2)) tick();
          do_write($urandom_range(0, 1) ? rand_clint_addr() : rand_ext_addr());
        end
      join
    end

    // Reset while an external read and an external write are in flight
    fork
      begin
        s_bus.arvalid = 1'b1; s_bus.araddr = 32'h8000_0100; s_bus.arsize = 3'd2;
        tick();
        s_bus.arvalid = 1'b0;
      end
      begin
        aw_handshake(32'h8000_0200, 3'd2);
        w_handshake(32'h1111_2222, 4'hF);
      end
    join
    chk("pre_rst_m_arvalid", m_bus.arvalid, 1);
    chk("pre_rst_m_awvalid", m_bus.awvalid, 1);
    chk("pre_rst_m_wvalid", m_bus.wvalid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_m_arvalid", m_bus.arvalid, 0);
    chk("async_m_awvalid", m_bus.awvalid, 0);
    chk("async_m_wvalid", m_bus.wvalid, 0);
    chk("async_arready", s_bus.arready, 1);
    chk("async_awready", s_bus.awready, 1);
    chk("async_wready", s_bus.wready, 0);
    chk("async_mtime", mtime, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    clint_read(BASE + 32'hBFF8, d, r);
    chk("post_rst_resp", r, 2'b00);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
